acl_poll_core: RTL

MMIO slot core that autonomously samples the ADXL362 accelerometer over SPI. It replaces software-driven SPI polling of the accelerometer. It sits in the MMIO subsystem on a standard slot interface and drives the acl_sclk/acl_mosi/acl_miso/acl_ss_n pins directly. A built-in period timer triggers a burst read of XDATA_L..ZDATA_H. The core then publishes sign-extended X/Y/Z results atomically, together with status flags and a sample counter.

---
 rtl/acl_poll_core.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/acl_poll_core.sv
// rtl/acl_poll_core.sv - autonomous ADXL362 burst-read poller on an MMIO slot
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   cs, read, write      slot select and strobes
//   addr[4:0]            word register address
//   wr_data[31:0]        write data
//   rd_data[31:0]        read data, combinational on addr
//   spi_sclk, spi_mosi   SPI mode 0 clock and data out
//   spi_miso             SPI data in
//   spi_ss_n             chip select, active low
module acl_poll_core #(
  parameter int DVSR_DEFAULT   = 50,
  parameter int PERIOD_DEFAULT = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_ss_n
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_LOW   = 3'd2;
  localparam logic [2:0] ST_HIGH  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  // Read command 0x0B, start address 0x0E (XDATA_L), then 6 dummy bytes.
  localparam logic [63:0] CMD_WORD = {8'h0B, 8'h0E, 48'h0};

  logic [2:0]  state;
  logic [15:0] cnt;
  logic [5:0]  bit_cnt;
  logic [63:0] sreg;
  logic [47:0] cap;      // only the six data bytes survive the 64 shifts
  logic        miso_bit;
  logic        enable;
  logic        pending;
  logic [31:0] tmr;
  logic [15:0] dvsr;
  logic [31:0] period;
  logic [31:0] x_reg, y_reg, z_reg;
  logic [31:0] sample_cnt;
  logic        new_data;
  logic        overrun;

  logic        wr_en, rd_z, trig, clr_ovr;
  logic [15:0] d_eff, d_load;
  logic [31:0] p_eff;
  logic        cnt_done, tmr_wrap, commit, start, busy;
  logic        unused_nibbles;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  assign wr_en    = cs & write;
  assign rd_z     = cs & read & (addr == 5'd5);
  assign trig     = wr_en & (addr == 5'd0) & wr_data[1];
  assign clr_ovr  = wr_en & (addr == 5'd0) & wr_data[3];
  assign d_eff    = (dvsr == 16'd0) ? 16'd1 : dvsr;
  assign d_load   = d_eff - 16'd1;
  assign p_eff    = (period == 32'd0) ? 32'd1 : period;
  assign cnt_done = (cnt == 16'd0);
  // >= rather than == so a PERIOD shrunk below the running count still wraps.
  assign tmr_wrap = enable & (tmr >= (p_eff - 32'd1));
  assign commit   = (state == ST_HOLD) & cnt_done;
  assign start    = (state == ST_IDLE) & pending;
  assign busy     = (state != ST_IDLE);

  // The high data nibbles carry only sign copies of bit 11.
  assign unused_nibbles = ^{cap[39:36], cap[23:20], cap[7:4]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      sreg       <= '0;
      cap        <= '0;
      miso_bit   <= 1'b0;
      spi_sclk   <= 1'b0;
      spi_mosi   <= 1'b0;
      spi_ss_n   <= 1'b1;
      enable     <= 1'b0;
      pending    <= 1'b0;
      tmr        <= '0;
      dvsr       <= 16'(DVSR_DEFAULT);
      period     <= 32'(PERIOD_DEFAULT);
      x_reg      <= '0;
      y_reg      <= '0;
      z_reg      <= '0;
      sample_cnt <= '0;
      new_data   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (wr_en) begin
        case (addr)
          5'd0:    enable <= wr_data[0];
          5'd1:    dvsr   <= wr_data[15:0];
          5'd2:    period <= wr_data;
          default: ;
        endcase
      end

      if (!enable || tmr_wrap) tmr <= '0;
      else                     tmr <= tmr + 32'd1;

      // A new trigger beats the IDLE consume so it is never lost.
      if (trig || tmr_wrap) pending <= 1'b1;
      else if (start)       pending <= 1'b0;

      // Commit beats a same-cycle Z read; that read counts as having
      // consumed the previous sample, so it is not an overrun.
      if (commit)    new_data <= 1'b1;
      else if (rd_z) new_data <= 1'b0;

      if (commit && new_data && !rd_z) overrun <= 1'b1;
      else if (clr_ovr)                overrun <= 1'b0;

      if (busy && !cnt_done) cnt <= cnt - 16'd1;

      case (state)
        ST_IDLE: begin
          if (pending) begin
            spi_ss_n <= 1'b0;
            sreg     <= CMD_WORD;
            bit_cnt  <= '0;
            cnt      <= d_load;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_done) begin
            spi_mosi <= sreg[63];
            cnt      <= d_load;
            state    <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (cnt_done) begin
            spi_sclk <= 1'b1;
            miso_bit <= spi_miso;
            cnt      <= d_load;
            state    <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (cnt_done) begin
            spi_sclk <= 1'b0;
            sreg     <= {sreg[62:0], 1'b0};
            cap      <= {cap[46:0], miso_bit};
            cnt      <= d_load;
            if (bit_cnt == 6'd63) begin
              spi_mosi <= 1'b0;
              state    <= ST_HOLD;
            end else begin
              spi_mosi <= sreg[62];
              bit_cnt  <= bit_cnt + 6'd1;
              state    <= ST_LOW;
            end
          end
        end
        ST_HOLD: begin
          if (cnt_done) begin
            spi_ss_n   <= 1'b1;
            x_reg      <= sext12({cap[35:32], cap[47:40]});
            y_reg      <= sext12({cap[19:16], cap[31:24]});
            z_reg      <= sext12({cap[3:0],   cap[15:8]});
            sample_cnt <= sample_cnt + 32'd1;
            cnt        <= d_load;
            state      <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (cnt_done) state <= ST_IDLE;
        end
        default: begin
          spi_sclk <= 1'b0;
          spi_ss_n <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      5'd0:    rd_data = {29'b0, overrun, new_data, busy};
      5'd1:    rd_data = {16'b0, dvsr};
      5'd2:    rd_data = period;
      5'd3:    rd_data = x_reg;
      5'd4:    rd_data = y_reg;
      5'd5:    rd_data = z_reg;
      5'd6:    rd_data = sample_cnt;
      default: rd_data = '0;
    endcase
  end

endmodule
